read_write_logic: RTL and testbench

//  Bus read/write front end of the 8259A-style PIC. Decodes CPU WR/RD strobes
//  (with CS and A0), steers the data-bus byte into ICW1..ICW4 / OCW1..OCW3, and

---
 rtl/read_write_logic_if.sv | 37 +++
 rtl/read_write_logic.sv | 161 ++++++++++++++++
 tb/tb_read_write_logic.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/read_write_logic_if.sv
// read_write_logic_if
//   Groups the CPU-side bus strobes and the command-word outputs of the
//   8259A-style read/write front end.
//   slave  : the read_write_logic block (samples strobes, drives command words)
//   master : the CPU / control-logic side (drives strobes, consumes words)
//   Signals: Read, write, CS (active-low strobes), A0, dataBuffer[7:0],
//            write_flag_ACK, write_flag, ICW1..ICW4, OCW1..OCW3,
//            read_cmd_to_ctrl_logic.
interface read_write_logic_if;
    logic       Read;
    logic       write;
    logic       A0;
    logic       CS;
    logic [7:0] dataBuffer;
    logic       write_flag_ACK;
    logic       write_flag;
    logic [7:0] ICW1;
    logic [7:0] ICW2;
    logic [7:0] ICW3;
    logic [7:0] ICW4;
    logic [7:0] OCW1;
    logic [7:0] OCW2;
    logic [7:0] OCW3;
    logic       read_cmd_to_ctrl_logic;

    modport slave (
        input  Read, write, A0, CS, dataBuffer, write_flag_ACK,
        output write_flag, ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3,
               read_cmd_to_ctrl_logic
    );

    modport master (
        output Read, write, A0, CS, dataBuffer, write_flag_ACK,
        input  write_flag, ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3,
               read_cmd_to_ctrl_logic
    );
endinterface

// File: rtl/read_write_logic.sv
// read_write_logic
//   Bus read/write front end of an 8259A-style PIC. Detects the falling edge
//   of WR# while CS# is low, steers the data byte into ICW1..ICW4 / OCW1..OCW3
//   following the initialisation sequence, raises write_flag until the control
//   logic acknowledges, and registers the status-read request.
//   Ports: clk, rst_n (synchronous, active-low), bus (read_write_logic_if.slave).
//   Option: define WR_SYNC_EN to pass write/Read/CS/A0/dataBuffer through a
//   2-flop synchroniser before decode (adds 2 cycles of latency).
//
//   state     | meaning
//   WAIT_ICW1 | after reset, only an ICW1 write is accepted
//   WAIT_ICW2 | ICW1 seen, next A0=1 write is ICW2
//   WAIT_ICW3 | cascade mode, next A0=1 write is ICW3
//   WAIT_ICW4 | IC4 set, next A0=1 write is ICW4
//   READY     | initialised, writes go to OCW1..OCW3
module read_write_logic (
    input logic               clk,
    input logic               rst_n,
    read_write_logic_if.slave bus
);
    typedef enum logic [2:0] {WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;

    state_t     state_q, state_d;
    logic       rd_i, wr_i, cs_i, a0_i;
    logic [7:0] d_i;
    logic       wr_q;
    logic       wstb;
    logic       ld_icw1, ld_icw2, ld_icw3, ld_icw4, ld_ocw1, ld_ocw2, ld_ocw3;
    logic       accept;
    logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q, ocw1_q, ocw2_q, ocw3_q;
    logic       flag_q, rd_cmd_q;

`ifdef WR_SYNC_EN
    logic [1:0] rd_s, wr_s, cs_s, a0_s;
    logic [7:0] d_s1, d_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_s <= 2'b11;
            wr_s <= 2'b11;
            cs_s <= 2'b11;
            a0_s <= 2'b00;
            d_s1 <= 8'h00;
            d_s2 <= 8'h00;
        end else begin
            rd_s <= {rd_s[0], bus.Read};
            wr_s <= {wr_s[0], bus.write};
            cs_s <= {cs_s[0], bus.CS};
            a0_s <= {a0_s[0], bus.A0};
            d_s1 <= bus.dataBuffer;
            d_s2 <= d_s1;
        end
    end

    assign rd_i = rd_s[1];
    assign wr_i = wr_s[1];
    assign cs_i = cs_s[1];
    assign a0_i = a0_s[1];
    assign d_i  = d_s2;
`else
    assign rd_i = bus.Read;
    assign wr_i = bus.write;
    assign cs_i = bus.CS;
    assign a0_i = bus.A0;
    assign d_i  = bus.dataBuffer;
`endif

    // One strobe per WR# low pulse: needs WR# high on the previous edge, so
    // CS# dropping while WR# is already low produces no write.
    assign wstb = !cs_i && !wr_i && wr_q;

    always_comb begin
        state_d = state_q;
        ld_icw1 = 1'b0;
        ld_icw2 = 1'b0;
        ld_icw3 = 1'b0;
        ld_icw4 = 1'b0;
        ld_ocw1 = 1'b0;
        ld_ocw2 = 1'b0;
        ld_ocw3 = 1'b0;
        if (wstb) begin
            if (!a0_i && d_i[4]) begin
                ld_icw1 = 1'b1;
                state_d = WAIT_ICW2;
            end else begin
                case (state_q)
                    WAIT_ICW2: if (a0_i) begin
                        ld_icw2 = 1'b1;
                        if (!icw1_q[1])     state_d = WAIT_ICW3;
                        else if (icw1_q[0]) state_d = WAIT_ICW4;
                        else                state_d = READY;
                    end
                    WAIT_ICW3: if (a0_i) begin
                        ld_icw3 = 1'b1;
                        state_d = icw1_q[0] ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: if (a0_i) begin
                        ld_icw4 = 1'b1;
                        state_d = READY;
                    end
                    // D4 is known to be 0 here when A0=0 (ICW1 caught above)
                    READY: begin
                        if (a0_i)        ld_ocw1 = 1'b1;
                        else if (!d_i[3]) ld_ocw2 = 1'b1;
                        else             ld_ocw3 = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        accept = ld_icw1 | ld_icw2 | ld_icw3 | ld_icw4 | ld_ocw1 | ld_ocw2 | ld_ocw3;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= WAIT_ICW1;
            wr_q     <= 1'b1;
            icw1_q   <= 8'h00;
            icw2_q   <= 8'h00;
            icw3_q   <= 8'h00;
            icw4_q   <= 8'h00;
            ocw1_q   <= 8'h00;
            ocw2_q   <= 8'h00;
            ocw3_q   <= 8'h00;
            flag_q   <= 1'b0;
            rd_cmd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_i;
            rd_cmd_q <= !cs_i && !rd_i && wr_i;
            if (accept)                  flag_q <= 1'b1;
            else if (bus.write_flag_ACK) flag_q <= 1'b0;
            if (ld_icw1) begin
                // A new ICW1 restarts initialisation from a clean slate
                icw1_q <= d_i;
                icw2_q <= 8'h00;
                icw3_q <= 8'h00;
                icw4_q <= 8'h00;
                ocw1_q <= 8'h00;
                ocw2_q <= 8'h00;
                ocw3_q <= 8'h00;
            end
            if (ld_icw2) icw2_q <= d_i;
            if (ld_icw3) icw3_q <= d_i;
            if (ld_icw4) icw4_q <= d_i;
            if (ld_ocw1) ocw1_q <= d_i;
            if (ld_ocw2) ocw2_q <= d_i;
            if (ld_ocw3) ocw3_q <= d_i;
        end
    end

    assign bus.ICW1                   = icw1_q;
    assign bus.ICW2                   = icw2_q;
    assign bus.ICW3                   = icw3_q;
    assign bus.ICW4                   = icw4_q;
    assign bus.OCW1                   = ocw1_q;
    assign bus.OCW2                   = ocw2_q;
    assign bus.OCW3                   = ocw3_q;
    assign bus.write_flag             = flag_q;
    assign bus.read_cmd_to_ctrl_logic = rd_cmd_q;
endmodule

// File: tb/tb_read_write_logic.sv
// tb_read_write_logic
//   Directed bench for read_write_logic (default build, WR_SYNC_EN undefined).
//   Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_read_write_logic;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    read_write_logic_if bus ();

    read_write_logic dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WR# low pulse of one cycle; ack is driven on the strobe edge.
    task automatic wr(input logic a0, input logic [7:0] d, input logic ack);
        bus.CS             = 1'b0;
        bus.A0             = a0;
        bus.dataBuffer     = d;
        bus.write          = 1'b0;
        bus.write_flag_ACK = ack;
        tick();
        bus.write          = 1'b1;
        bus.CS             = 1'b1;
        bus.write_flag_ACK = 1'b0;
        tick();
    endtask

    task automatic ack();
        bus.write_flag_ACK = 1'b1;
        tick();
        bus.write_flag_ACK = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] i1, input logic [7:0] i2,
                           input logic [7:0] i3, input logic [7:0] i4, input logic [7:0] o1,
                           input logic [7:0] o2, input logic [7:0] o3);
        chk({tag, ".icw1"}, bus.ICW1, i1);
        chk({tag, ".icw2"}, bus.ICW2, i2);
        chk({tag, ".icw3"}, bus.ICW3, i3);
        chk({tag, ".icw4"}, bus.ICW4, i4);
        chk({tag, ".ocw1"}, bus.OCW1, o1);
        chk({tag, ".ocw2"}, bus.OCW2, o2);
        chk({tag, ".ocw3"}, bus.OCW3, o3);
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        rst_n              = 1'b0;
        bus.Read           = 1'b1;
        bus.write          = 1'b1;
        bus.CS             = 1'b1;
        bus.A0             = 1'b0;
        bus.dataBuffer     = 8'h00;
        bus.write_flag_ACK = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // reset state
        chk_all("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("rst.flag", {7'd0, bus.write_flag}, 8'h00);
        chk("rst.rd",   {7'd0, bus.read_cmd_to_ctrl_logic}, 8'h00);

        // writes before ICW1 are ignored
        wr(1'b1, 8'hAA, 1'b0);
        wr(1'b0, 8'h0B, 1'b0);
        chk_all("pre", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("pre.flag", {7'd0, bus.write_flag}, 8'h00);

        // full init: cascade + IC4
        wr(1'b0, 8'h11, 1'b0);
        chk("i1", bus.ICW1, 8'h11);
        chk("i1.flag", {7'd0, bus.write_flag}, 8'h01);
        ack();
        chk("i1.ack", {7'd0, bus.write_flag}, 8'h00);
        wr(1'b1, 8'h17, 1'b0);
        chk("i2.flag", {7'd0, bus.write_flag}, 8'h01);
        ack();
        wr(1'b1, 8'h55, 1'b0);
        ack();
        wr(1'b1, 8'h8F, 1'b0);
        chk("i4.flag", {7'd0, bus.write_flag}, 8'h01);
        ack();
        chk("i4.ack", {7'd0, bus.write_flag}, 8'h00);
        chk_all("init", 8'h11, 8'h17, 8'h55, 8'h8F, 8'h00, 8'h00, 8'h00);

        // OCW decode in READY
        wr(1'b0, 8'h20, 1'b0);
        wr(1'b0, 8'h0B, 1'b0);
        ack();
        chk_all("ocw", 8'h11, 8'h17, 8'h55, 8'h8F, 8'h00, 8'h20, 8'h0B);

        // WR# held low 10 cycles: one write only
        bus.CS         = 1'b0;
        bus.A0         = 1'b1;
        bus.dataBuffer = 8'h3C;
        bus.write      = 1'b0;
        tick();
        chk("hold.ocw1", bus.OCW1, 8'h3C);
        chk("hold.flag", {7'd0, bus.write_flag}, 8'h01);
        ack();
        bus.dataBuffer = 8'hC3;
        repeat (8) tick();
        chk("hold.flag2", {7'd0, bus.write_flag}, 8'h00);
        chk("hold.ocw1b", bus.OCW1, 8'h3C);
        bus.write = 1'b1;
        bus.CS    = 1'b1;
        tick();

        // CS# high: ignored
        bus.A0         = 1'b1;
        bus.dataBuffer = 8'h99;
        bus.write      = 1'b0;
        tick();
        // CS# falls while WR# already low: no edge, ignored
        bus.CS = 1'b0;
        tick();
        tick();
        chk("cs.ocw1", bus.OCW1, 8'h3C);
        chk("cs.flag", {7'd0, bus.write_flag}, 8'h00);
        bus.write = 1'b1;
        bus.CS    = 1'b1;
        tick();

        // ACK and new write on the same edge: flag stays set
        wr(1'b1, 8'h5A, 1'b0);
        wr(1'b1, 8'hA5, 1'b1);
        chk("same.flag", {7'd0, bus.write_flag}, 8'h01);
        chk("same.ocw1", bus.OCW1, 8'hA5);
        ack();

        // status read: one-cycle latency, level
        bus.CS   = 1'b0;
        bus.Read = 1'b0;
        chk("rd.pre", {7'd0, bus.read_cmd_to_ctrl_logic}, 8'h00);
        tick();
        chk("rd.on", {7'd0, bus.read_cmd_to_ctrl_logic}, 8'h01);
        tick();
        chk("rd.hold", {7'd0, bus.read_cmd_to_ctrl_logic}, 8'h01);
        bus.Read = 1'b1;
        tick();
        chk("rd.off", {7'd0, bus.read_cmd_to_ctrl_logic}, 8'h00);
        // RD# and WR# both low: write only
        bus.Read       = 1'b0;
        bus.A0         = 1'b1;
        bus.dataBuffer = 8'h77;
        bus.write      = 1'b0;
        tick();
        chk("rdwr.rd", {7'd0, bus.read_cmd_to_ctrl_logic}, 8'h00);
        chk("rdwr.ocw1", bus.OCW1, 8'h77);
        bus.Read  = 1'b1;
        bus.write = 1'b1;
        bus.CS    = 1'b1;
        tick();
        ack();

        // ICW1 rewrite mid-READY: single, IC4 -> skips ICW3
        wr(1'b0, 8'h13, 1'b0);
        chk_all("re", 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        ack();
        wr(1'b0, 8'h0B, 1'b0);
        chk("wait.ocw3", bus.OCW3, 8'h00);
        chk("wait.flag", {7'd0, bus.write_flag}, 8'h00);
        wr(1'b1, 8'h20, 1'b0);
        wr(1'b1, 8'h01, 1'b0);
        wr(1'b1, 8'hF0, 1'b0);
        chk_all("short", 8'h13, 8'h20, 8'h00, 8'h01, 8'hF0, 8'h00, 8'h00);
        ack();

        // cascade without IC4: ICW3 leads straight to READY
        wr(1'b0, 8'h10, 1'b0);
        wr(1'b1, 8'h08, 1'b0);
        wr(1'b1, 8'h04, 1'b0);
        wr(1'b1, 8'h66, 1'b0);
        chk_all("noic4", 8'h10, 8'h08, 8'h04, 8'h00, 8'h66, 8'h00, 8'h00);
        ack();

        // reset mid-sequence
        wr(1'b0, 8'h11, 1'b0);
        wr(1'b1, 8'h22, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_all("mrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("mrst.flag", {7'd0, bus.write_flag}, 8'h00);
        wr(1'b1, 8'hAA, 1'b0);
        chk("mrst.icw2", bus.ICW2, 8'h00);
        chk("mrst.flag2", {7'd0, bus.write_flag}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
